// File: rtl/ftoi_pkg.sv
// Shared FPU constants and the ftoi pipeline-stage record.
package ftoi_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  // Exponent thresholds: |x| >= 2^31, m already integral, |x| >= 0.5.
  localparam logic [EXP_W-1:0] E_SAT  = EXP_W'(BIAS + 31);
  localparam logic [EXP_W-1:0] E_INT  = EXP_W'(BIAS + MAN_W);
  localparam logic [EXP_W-1:0] E_HALF = EXP_W'(BIAS - 1);

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef struct packed {
    logic        s;
    logic        sat;
    logic [31:0] mag;
    logic        rnd;
  } stg_t;
endpackage

// File: rtl/ftoi_shift.sv
// Barrel shift of the 24-bit significand to an integer magnitude plus the
// first shifted-out bit (round-half-away when added to the magnitude).
module ftoi_shift
  import ftoi_pkg::*;
(
  input  logic [EXP_W-1:0] e,
  input  logic [MAN_W:0]   m,
  output logic [31:0]      mag,
  output logic             rnd
);
  logic [2:0]       lsh;
  logic [4:0]       rsh;
  logic [MAN_W+1:0] rext;

  assign lsh  = 3'(e - E_INT);
  assign rsh  = 5'(E_INT - e);
  // Guard bit appended so bit 0 after the shift is m[rsh-1].
  assign rext = {m, 1'b0} >> rsh;

  always_comb begin
    mag = '0;
    rnd = 1'b0;
    if (e >= E_INT) begin
      mag = 32'(m) << lsh;
    end else if (e >= E_HALF) begin
      mag = 32'(rext[MAN_W+1:1]);
      rnd = rext[0];
    end
  end
endmodule

// File: rtl/ftoi.sv
// Float32 -> int32, round half away from zero, saturating to INT_MIN; 3-cycle latency.
module ftoi
  import ftoi_pkg::*;
(
  input  logic [31:0] x1,
  output logic [31:0] y,
  input  logic        clk,
  input  logic        rst
);
  logic [31:0] sh_mag;
  logic        sh_rnd;
  stg_t        s1_d, st1, st2;
  logic [31:0] y_d;

  ftoi_shift u_shift (
    .e   (x1[30:23]),
    .m   ({1'b1, x1[22:0]}),
    .mag (sh_mag),
    .rnd (sh_rnd)
  );

  assign s1_d = '{s: x1[31], sat: (x1[30:23] >= E_SAT), mag: sh_mag, rnd: sh_rnd};

  // Saturation overrides sign, so -2^31 exactly also lands on INT_MIN.
  assign y_d = st2.sat ? INT_MIN : (st2.s ? -st2.mag : st2.mag);

  always_ff @(posedge clk) begin
    if (rst) begin
      st1 <= '0;
      st2 <= '0;
      y   <= '0;
    end else begin
      st1 <= s1_d;
      st2 <= '{s: st1.s, sat: st1.sat, mag: st1.mag + 32'(st1.rnd), rnd: 1'b0};
      y   <= y_d;
    end
  end
endmodule

// File: tb/tb_ftoi.sv
// Self-checking bench for ftoi: directed corner cases, random stream, mid-stream reset.
module tb_ftoi;
  logic [31:0] x1;
  logic [31:0] y;
  logic        clk;
  logic        rst;

  int tests;
  int fails;

  logic [31:0] exp_q[$];
  logic [31:0] op_q[$];

  ftoi dut (.x1(x1), .y(y), .clk(clk), .rst(rst));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value = m * 2^(e-150); integer part plus one if the fraction is >= 1/2.
  function automatic logic [31:0] ref_ftoi(input logic [31:0] f);
    int     e;
    int     sh;
    longint m, ip, rem, mag;
    e = int'(f[30:23]);
    m = longint'({1'b1, f[22:0]});
    if (e >= 158) return 32'h8000_0000;
    if (e >= 150) begin
      mag = m * (64'sd1 <<< (e - 150));
    end else if (e < 100) begin
      mag = 0;
    end else begin
      sh  = 150 - e;
      ip  = m / (64'sd1 <<< sh);
      rem = m - ip * (64'sd1 <<< sh);
      mag = ip + ((2 * rem >= (64'sd1 <<< sh)) ? 64'sd1 : 64'sd0);
    end
    return f[31] ? 32'(-mag) : 32'(mag);
  endfunction

  // One clock: check the output due now, then drive the next operand.
  // A reset cycle discards everything in flight; the cleared stages give 0.
  task automatic cycle(input logic [31:0] v, input logic r);
    logic [31:0] ev, eo;
    @(posedge clk);
    #1;
    if (exp_q.size() >= 3) begin
      ev = exp_q.pop_front();
      eo = op_q.pop_front();
      tests++;
      assert (y === ev) else begin
        fails++;
        $error("FAIL y(x1=%h): got %h expected %h", eo, y, ev);
      end
    end
    x1  = v;
    rst = r;
    if (r) begin
      exp_q = '{32'h0, 32'h0, 32'h0};
      op_q  = '{32'h0, 32'h0, 32'h0};
    end else begin
      exp_q.push_back(ref_ftoi(v));
      op_q.push_back(v);
    end
  endtask

  task automatic rand_op(output logic [31:0] v);
    logic [31:0] r;
    logic [7:0]  e;
    r = $urandom;
    e = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(120, 160));
    v = {r[31], e, r[22:0]};
  endtask

  logic [31:0] dir [14];
  logic [31:0] dexp[14];
  logic [31:0] v;

  initial begin
    tests = 0;
    fails = 0;
    x1    = '0;
    rst   = 1'b1;

    dir = '{32'h3F80_0000, 32'h0000_0000, 32'h8000_0000, 32'h3EFF_FFFF, 32'h3F00_0000,
            32'h4020_0000, 32'hC020_0000, 32'h3FC0_0000, 32'h4B7F_FFFF,
            32'h4EFF_FFFF, 32'h4F00_0000, 32'hCF00_0000, 32'h7F80_0000, 32'h7FC0_0000};
    dexp = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd1,
             32'd3, 32'hFFFF_FFFD, 32'd2, 32'd16777215,
             32'h7FFF_FF80, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};

    // Reference model must agree with the hand-derived expectations first.
    for (int i = 0; i < 14; i++) begin
      tests++;
      assert (ref_ftoi(dir[i]) === dexp[i]) else begin
        fails++;
        $error("FAIL model(x1=%h): got %h expected %h", dir[i], ref_ftoi(dir[i]), dexp[i]);
      end
    end

    // Reset from power-up; the three cycles afterwards must read 0.
    cycle(32'h3F80_0000, 1'b1);
    cycle(32'h3F80_0000, 1'b1);

    for (int i = 0; i < 14; i++) cycle(dir[i], 1'b0);

    for (int i = 0; i < 100; i++) begin
      rand_op(v);
      cycle(v, 1'b0);
    end

    // Mid-stream reset: in-flight operands are dropped.
    for (int i = 0; i < 5; i++) begin
      rand_op(v);
      cycle(v, 1'b0);
    end
    cycle(32'h4020_0000, 1'b1);
    cycle(32'hC020_0000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      rand_op(v);
      cycle(v, 1'b0);
    end

    for (int i = 0; i < 3; i++) cycle(32'h0, 1'b0);
    // Final drain check for the last queued operands.
    cycle(32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
